// File: rtl/udp_loopback_pkg.sv
// udp_loopback_pkg
// Purpose: shared types and default sizing for the UDP loopback echo block.
//   state_t        FSM state encoding used by udp_loopback and exposed on its
//                  debug output.
//   BUF_DEPTH_DEF  default payload buffer size in bytes (power of two).
//   MAX_LEN_DEF    default largest payload that is echoed.
package udp_loopback_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    WAIT_RDY = 3'd2,
    SEND     = 3'd3,
    DROP     = 3'd4
  } state_t;

  localparam int BUF_DEPTH_DEF = 2048;
  localparam int MAX_LEN_DEF   = 1472;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/udp_loopback_if.sv
// udp_loopback_if
// Purpose: bundles the payload-side signals between the eth UDP core and the
// loopback block.
//   slave  modport: loopback side (receives rx bytes, answers tx requests)
//   master modport: eth core side
//
// Handshake rules:
//   rx: a byte is transferred in every cycle udp_rx_data_vld=1 (no
//       back-pressure). udp_rx_done is a one-cycle pulse that ends the
//       datagram; it may coincide with the last valid byte.
//   tx: udp_tx_en is a one-cycle pulse that starts a transmission of
//       udp_tx_data_num bytes. Each cycle udp_tx_req=1 asks for one byte; that
//       byte appears on udp_tx_data exactly one cycle later, and udp_tx_data
//       is 0 in every cycle that does not follow an accepted request.
interface udp_loopback_if;
  logic        udp_rx_data_vld;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_done;
  logic        tx_rdy;
  logic        udp_tx_req;
  logic        udp_tx_en;
  logic [7:0]  udp_tx_data;
  logic [15:0] udp_tx_data_num;
  logic [15:0] drop_cnt;

  modport slave (
    input  udp_rx_data_vld, udp_rx_data, udp_rx_done, tx_rdy, udp_tx_req,
    output udp_tx_en, udp_tx_data, udp_tx_data_num, drop_cnt
  );

  modport master (
    output udp_rx_data_vld, udp_rx_data, udp_rx_done, tx_rdy, udp_tx_req,
    input  udp_tx_en, udp_tx_data, udp_tx_data_num, drop_cnt
  );
endinterface

// File: rtl/udp_loopback_sdp_ram.sv
// lb_sdp_ram
// Purpose: simple dual-port byte RAM holding one datagram payload.
// Ports:
//   clk      clock
//   we       write enable, wr_addr/wr_data written at the clock edge
//   re       read enable, rd_data updated from rd_addr at the clock edge
//   rd_data  registered read data (one-cycle latency); contents not reset
module lb_sdp_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_loopback.sv
// udp_loopback
// Purpose: receives a UDP payload into a single buffer and echoes it back
// through the eth core's byte-request transmit interface. Datagrams that are
// too long, or that arrive while an echo is pending, are dropped.
// Ports:
//   clk        sole clock (gmii_tx_clk domain)
//   rst        synchronous active-high reset
//   bus        udp_loopback_if.slave payload rx/tx signals and drop_cnt
//   dbg_state  current FSM state
// Build option: define UDP_LOOPBACK_STATS_EN to enable the saturating
// drop_cnt counter; otherwise drop_cnt is tied to 0.
module udp_loopback
  import udp_loopback_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  udp_loopback_if.slave        bus,
  output state_t               dbg_state
);

  localparam int AW = $clog2(BUF_DEPTH);
  // A byte is refused once the stored count reaches the smaller of the two limits.
  localparam logic [15:0] LIMIT = 16'(min_int(MAX_LEN, BUF_DEPTH));

  state_t        state, state_nxt;
  logic [15:0]   wr_cnt, wr_cnt_nxt, rd_cnt, tx_num;
  logic          skip_rx;   // inside a datagram that is being discarded as busy
  logic          rd_vld_q;  // udp_tx_data carries a requested byte this cycle
  logic          rx_full, busy_drop, tx_last;
  logic          ram_we, ram_re, tx_en;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_q;

  assign rx_full   = (wr_cnt >= LIMIT);
  assign busy_drop = bus.udp_rx_data_vld && !skip_rx &&
                     ((state == WAIT_RDY) || (state == SEND));
  assign tx_last   = ((rd_cnt + 16'd1) == tx_num);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.udp_rx_data_vld && !skip_rx)
          state_nxt = bus.udp_rx_done ? WAIT_RDY : RECV;
      end
      RECV: begin
        if (bus.udp_rx_data_vld && rx_full)
          state_nxt = bus.udp_rx_done ? IDLE : DROP;
        else if (bus.udp_rx_done)
          state_nxt = WAIT_RDY;
      end
      WAIT_RDY: if (bus.tx_rdy) state_nxt = SEND;
      SEND:     if (bus.udp_tx_req && tx_last) state_nxt = IDLE;
      DROP:     if (bus.udp_rx_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = wr_cnt[AW-1:0];
    tx_en     = 1'b0;
    case (state)
      IDLE: begin
        ram_we    = bus.udp_rx_data_vld && !skip_rx;
        ram_waddr = '0;
      end
      RECV:     ram_we = bus.udp_rx_data_vld && !rx_full;
      WAIT_RDY: tx_en  = bus.tx_rdy;
      SEND:     ram_re = bus.udp_tx_req;
      default:  ;
    endcase
  end

  // Length after this cycle's write; the first byte restarts the count at 1.
  always_comb begin
    wr_cnt_nxt = wr_cnt;
    if (ram_we) wr_cnt_nxt = (state == IDLE) ? 16'd1 : wr_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      tx_num   <= '0;
      skip_rx  <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      wr_cnt   <= wr_cnt_nxt;
      rd_vld_q <= ram_re;
      if (state_nxt == WAIT_RDY && state != WAIT_RDY) tx_num <= wr_cnt_nxt;
      if (state != SEND)  rd_cnt <= '0;
      else if (ram_re)    rd_cnt <= rd_cnt + 16'd1;
      if (bus.udp_rx_done) skip_rx <= 1'b0;
      else if (busy_drop)  skip_rx <= 1'b1;
    end
  end

  lb_sdp_ram #(.DEPTH(BUF_DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (bus.udp_rx_data),
    .re      (ram_re),
    .rd_addr (rd_cnt[AW-1:0]),
    .rd_data (ram_q)
  );

`ifdef UDP_LOOPBACK_STATS_EN
  logic        drop_inc;
  logic [15:0] drop_q;
  assign drop_inc = (state == RECV && bus.udp_rx_data_vld && rx_full) || busy_drop;
  always_ff @(posedge clk) begin
    if (rst)                               drop_q <= '0;
    else if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.udp_tx_en       = tx_en;
  assign bus.udp_tx_data     = rd_vld_q ? ram_q : 8'h00;
  assign bus.udp_tx_data_num = tx_num;
  assign dbg_state           = state;

endmodule

// File: tb/tb_udp_loopback.sv
// tb_udp_loopback
// Purpose: self-checking bench for udp_loopback: a table of datagram
// scenarios with fixed expectations, hand-written reset/idle sequences, and
// randomized datagrams whose expectations come from a datagram-level model.
module tb_udp_loopback;
  import udp_loopback_pkg::*;

  localparam int MAX_LEN = 1472;
`ifdef UDP_LOOPBACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  udp_loopback_if bus();

  udp_loopback dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mdl_drop = 0;
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];

  logic        o_en;
  logic [7:0]  o_data;
  logic [15:0] o_num, o_drop;
  state_t      o_state;

  typedef struct {
    int         len;
    logic [7:0] first;
    logic [7:0] step;
    bit         last_done;
    int         rdy_delay;
    bit         intrude;
    bit         exp_en;
    int         exp_num;
    int         exp_drop_inc;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop();
    if (!STATS) return 16'h0000;
    return (mdl_drop > 65535) ? 16'hFFFF : 16'(mdl_drop);
  endfunction

  // One clock cycle: drive inputs just after the rising edge, sample outputs
  // at the falling edge, then advance past the next rising edge.
  task automatic cyc(input logic vld, input logic [7:0] d, input logic done,
                     input logic rdy, input logic req);
    bus.udp_rx_data_vld = vld;
    bus.udp_rx_data     = d;
    bus.udp_rx_done     = done;
    bus.tx_rdy          = rdy;
    bus.udp_tx_req      = req;
    @(negedge clk);
    o_en    = bus.udp_tx_en;
    o_data  = bus.udp_tx_data;
    o_num   = bus.udp_tx_data_num;
    o_drop  = bus.drop_cnt;
    o_state = dbg_state;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_phase(input int len, input bit last_done, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rx_gap_en", o_en, 0);
      end
      cyc(1'b1, pay_q[i], last_done && (i == len - 1), 1'b0, 1'b0);
      chk("rx_en", o_en, 0);
    end
    if (!last_done) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("done_en", o_en, 0);
    end
  endtask

  // Deliver pay_q as one datagram, then play the eth transmitter side.
  task automatic run_dgram(input int len, input bit last_done, input int rdy_delay,
                           input bit intrude, input bit exp_en, input int exp_num,
                           input int exp_drop_inc, input bit gaps);
    int reqs, ir, ilen, guard;
    bit pend;
    logic [7:0] pend_exp, idat;
    logic req_now, iv, idn;
    exp_q = pay_q;
    rx_phase(len, last_done, gaps);
    if (!exp_en) begin
      for (int i = 0; i < 3; i++) begin
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("dropped_no_en", o_en, 0);
      end
    end else begin
      for (int i = 0; i < rdy_delay; i++) begin
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("wait_en", o_en, 0);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("tx_en_pulse", o_en, 1);
      chk("tx_num", o_num, exp_num);
      reqs = 0; pend = 0; ir = 0; guard = 0; pend_exp = 8'h00;
      ilen = intrude ? $urandom_range(1, 6) : 0;
      while ((reqs < len || pend || ir < ilen) && guard < 8000) begin
        req_now = (reqs < len) && (!gaps || $urandom_range(0, 2) != 0);
        iv   = (ir < ilen);
        idn  = iv && (ir == ilen - 1);
        idat = 8'($urandom);
        if (iv) ir++;
        cyc(iv, idat, idn, 1'b0, req_now);
        chk("send_en", o_en, 0);
        chk("send_num", o_num, exp_num);
        if (pend) chk("tx_data", o_data, pend_exp);
        pend = req_now;
        if (req_now) begin
          pend_exp = exp_q.pop_front();
          reqs++;
        end
        guard++;
      end
      if (guard >= 8000) begin
        total++; bad++;
        $display("FAIL send_timeout: got %0d requests want %0d", reqs, len);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("post_data", o_data, 0);
      chk("post_state", o_state, IDLE);
    end
    mdl_drop += exp_drop_inc;
    chk("drop_cnt", o_drop, exp_drop());
  endtask

  initial begin
    logic [7:0] b;
    int len;
    bit ld, intr, en;
    // len first step last_done rdy_delay intrude | exp_en exp_num exp_drop_inc
    tbl[0] = '{4,    8'h11, 8'h11, 1'b0, 0,  1'b0, 1'b1, 4,    0};
    tbl[1] = '{3,    8'hA0, 8'h01, 1'b0, 20, 1'b0, 1'b1, 3,    0};
    tbl[2] = '{1500, 8'h00, 8'h01, 1'b0, 0,  1'b0, 1'b0, 0,    1};
    tbl[3] = '{1,    8'h5A, 8'h00, 1'b0, 0,  1'b0, 1'b1, 1,    0};
    tbl[4] = '{8,    8'h30, 8'h03, 1'b0, 2,  1'b1, 1'b1, 8,    1};
    tbl[5] = '{5,    8'hC1, 8'h07, 1'b1, 1,  1'b0, 1'b1, 5,    0};
    tbl[6] = '{1,    8'hE7, 8'h00, 1'b1, 0,  1'b0, 1'b1, 1,    0};
    tbl[7] = '{1472, 8'h01, 8'h05, 1'b1, 0,  1'b0, 1'b1, 1472, 0};
    tbl[8] = '{1473, 8'h02, 8'h09, 1'b1, 0,  1'b0, 1'b0, 0,    1};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    chk("rst_en", o_en, 0);
    chk("rst_data", o_data, 0);
    chk("rst_num", o_num, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_state", o_state, IDLE);
    rst = 1'b0;

    // A lone done in IDLE is a zero-length datagram and must be ignored.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("zero_len_state", o_state, IDLE);
    chk("zero_len_en", o_en, 0);

    for (int k = 0; k < 9; k++) begin
      pay_q.delete();
      b = tbl[k].first;
      for (int i = 0; i < tbl[k].len; i++) begin
        pay_q.push_back(b);
        b = b + tbl[k].step;
      end
      run_dgram(tbl[k].len, tbl[k].last_done, tbl[k].rdy_delay, tbl[k].intrude,
                tbl[k].exp_en, tbl[k].exp_num, tbl[k].exp_drop_inc, 1'b0);
    end

    // Reset in the middle of an 8-byte echo, after two bytes have been read.
    pay_q.delete();
    for (int i = 0; i < 8; i++) pay_q.push_back(8'(8'h80 + i));
    rx_phase(8, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_en", o_en, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_b0", o_data, 8'h80);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_b1", o_data, 8'h81);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    mdl_drop = 0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("after_rst_state", o_state, IDLE);
    chk("after_rst_en", o_en, 0);
    chk("after_rst_data", o_data, 0);
    chk("after_rst_num", o_num, 0);
    chk("after_rst_drop", o_drop, 0);
    pay_q.delete();
    for (int i = 0; i < 6; i++) pay_q.push_back(8'(8'h3C ^ (i * 17)));
    run_dgram(6, 1'b0, 0, 1'b0, 1'b1, 6, 0, 1'b0);

    // Random datagrams: echoed iff length <= MAX_LEN; an intruder arriving
    // during the echo costs one drop and leaves the echo intact.
    for (int n = 0; n < 40; n++) begin
      len = ($urandom_range(0, 9) == 0) ? MAX_LEN + int'($urandom_range(1, 4))
                                        : int'($urandom_range(1, 24));
      pay_q.delete();
      for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
      ld   = $urandom_range(0, 1) == 1;
      en   = (len <= MAX_LEN);
      intr = en && ($urandom_range(0, 2) == 0);
      run_dgram(len, ld, $urandom_range(0, 4), intr, en, en ? len : 0,
                (en ? 0 : 1) + (intr ? 1 : 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
